// File: rtl/cnt_seq.sv
// cnt_seq: command sequencer and shadow checker for a 4-bit up/down counter.
// Drives the counter through clear, load and run, counts its CO pulses, and
// keeps a shadow copy of the expected Q to flag any divergence.
module cnt_seq (
    input  logic       CLK,
    input  logic       MR,
    input  logic       START,
    input  logic       DIR,
    input  logic [3:0] START_VAL,
    input  logic [3:0] NUM_TC,
    input  logic       PAUSE,
    input  logic [3:0] Q_IN,
    input  logic       CO_IN,
    output logic       C_MR,
    output logic       C_Load,
    output logic       C_EN,
    output logic       C_Up_Dn,
    output logic [3:0] C_D,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERR,
    output logic [3:0] TC_CNT
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    state_t     state;
    logic       dir_lat;
    logic [3:0] start_val_lat;
    logic [3:0] num_tc_lat;
    logic [3:0] exp_q;
    logic [3:0] tc_next;
    logic       tc_pulse;
    logic       tc_last;
    logic       check_en;

    // A CO pulse only counts when we were actually enabling the counter.
    // NUM_TC of 0 naturally ends on the 16th pulse because tc_next wraps.
    assign tc_next  = TC_CNT + 4'd1;
    assign tc_pulse = CO_IN & C_EN;
    assign tc_last  = tc_pulse & (tc_next == num_tc_lat);
    assign check_en = (state == S_RUN) || (state == S_DONE);

    // Sequencer: every control output is registered alongside the state it belongs to.
    always_ff @(posedge CLK) begin
        if (MR) begin
            state         <= S_IDLE;
            C_MR          <= 1'b0;
            C_Load        <= 1'b1;
            C_EN          <= 1'b0;
            C_Up_Dn       <= 1'b0;
            C_D           <= 4'd0;
            BUSY          <= 1'b0;
            DONE          <= 1'b0;
            ERR           <= 1'b0;
            TC_CNT        <= 4'd0;
            dir_lat       <= 1'b0;
            start_val_lat <= 4'd0;
            num_tc_lat    <= 4'd0;
        end else begin
            if (check_en && (Q_IN != exp_q)) begin
                ERR <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    C_MR    <= 1'b0;
                    C_Load  <= 1'b1;
                    C_EN    <= 1'b0;
                    C_Up_Dn <= 1'b0;
                    C_D     <= 4'd0;
                    DONE    <= 1'b0;
                    BUSY    <= 1'b0;
                    if (START) begin
                        dir_lat       <= DIR;
                        start_val_lat <= START_VAL;
                        num_tc_lat    <= NUM_TC;
                        ERR           <= 1'b0;
                        TC_CNT        <= 4'd0;
                        C_MR          <= 1'b1;
                        BUSY          <= 1'b1;
                        state         <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    C_MR    <= 1'b0;
                    C_Load  <= 1'b0;
                    C_D     <= start_val_lat;
                    C_Up_Dn <= dir_lat;
                    state   <= S_LOAD;
                end
                S_LOAD: begin
                    C_Load <= 1'b1;
                    C_D    <= 4'd0;
                    C_EN   <= ~PAUSE;
                    state  <= S_RUN;
                end
                S_RUN: begin
                    if (tc_pulse) begin
                        TC_CNT <= tc_next;
                    end
                    // The terminal pulse stops the counter even if PAUSE is also high.
                    if (tc_last) begin
                        C_EN  <= 1'b0;
                        DONE  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        C_EN <= ~PAUSE;
                    end
                end
                S_DONE: begin
                    DONE    <= 1'b0;
                    BUSY    <= 1'b0;
                    C_Up_Dn <= 1'b0;
                    state   <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Shadow counter: applies our own registered commands with the counter's priority.
    always_ff @(posedge CLK) begin
        if (MR) begin
            exp_q <= 4'd0;
        end else if (C_MR) begin
            exp_q <= 4'd0;
        end else if (!C_Load) begin
            exp_q <= C_D;
        end else if (C_EN) begin
            exp_q <= C_Up_Dn ? (exp_q + 4'd1) : (exp_q - 4'd1);
        end
    end

endmodule

// File: tb/tb_cnt_seq.sv
// tb_cnt_seq: drives cnt_seq against a behavioural 4-bit counter and checks
// sequence length, pulse count and error flag through a DONE-driven scoreboard.
module tb_cnt_seq;

    logic       CLK = 1'b0;
    logic       MR = 1'b1;
    logic       START = 1'b0;
    logic       DIR = 1'b0;
    logic [3:0] START_VAL = 4'd0;
    logic [3:0] NUM_TC = 4'd0;
    logic       PAUSE = 1'b0;
    logic [3:0] Q_IN;
    logic       CO_IN;
    logic       C_MR;
    logic       C_Load;
    logic       C_EN;
    logic       C_Up_Dn;
    logic [3:0] C_D;
    logic       BUSY;
    logic       DONE;
    logic       ERR;
    logic [3:0] TC_CNT;

    logic       fault = 1'b0;
    logic [3:0] cq = 4'd0;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;

    typedef struct {
        int done_edge;
        int tc;
        int err;
    } exp_t;
    exp_t sb[$];

    cnt_seq dut (
        .CLK(CLK), .MR(MR), .START(START), .DIR(DIR), .START_VAL(START_VAL),
        .NUM_TC(NUM_TC), .PAUSE(PAUSE), .Q_IN(Q_IN), .CO_IN(CO_IN),
        .C_MR(C_MR), .C_Load(C_Load), .C_EN(C_EN), .C_Up_Dn(C_Up_Dn), .C_D(C_D),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .TC_CNT(TC_CNT)
    );

    // Free-running clock.
    always #5 CLK = ~CLK;

    // Edge counter: at a falling edge cyc equals the number of rising edges so far.
    always @(posedge CLK) cyc <= cyc + 1;

    // The counter being sequenced, with an optional one-bit corruption of Q.
    always @(posedge CLK) begin
        if (C_MR) cq <= 4'd0;
        else if (!C_Load) cq <= C_D;
        else if (C_EN) cq <= C_Up_Dn ? cq + 4'd1 : cq - 4'd1;
    end
    assign Q_IN  = cq ^ {3'b000, fault};
    assign CO_IN = C_EN && (C_Up_Dn ? (cq == 4'd15) : (cq == 4'd0));

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d (edge %0d)", name, actual, expected, cyc);
        end
    endtask

    // Enabled counter cycles needed to see N terminal pulses from a loaded value.
    function automatic int expEnabled(input logic dir, input logic [3:0] sv, input logic [3:0] ntc);
        int n;
        n = (ntc == 4'd0) ? 16 : int'(ntc);
        if (dir) return (16 - int'(sv)) + 16 * (n - 1);
        return int'(sv) + 1 + 16 * (n - 1);
    endfunction

    task automatic checkReset(input string tag);
        checkOutput({tag, "_c_mr"}, int'(C_MR), 0);
        checkOutput({tag, "_c_load"}, int'(C_Load), 1);
        checkOutput({tag, "_c_en"}, int'(C_EN), 0);
        checkOutput({tag, "_c_up_dn"}, int'(C_Up_Dn), 0);
        checkOutput({tag, "_c_d"}, int'(C_D), 0);
        checkOutput({tag, "_busy"}, int'(BUSY), 0);
        checkOutput({tag, "_done"}, int'(DONE), 0);
        checkOutput({tag, "_err"}, int'(ERR), 0);
        checkOutput({tag, "_tc_cnt"}, int'(TC_CNT), 0);
    endtask

    // One full sequence: pauses for pl edges starting pa edges into the run,
    // optional pause on the terminal edge, optional Q corruption, optional START held while busy.
    task automatic applyStimulus(input logic dir, input logic [3:0] sv, input logic [3:0] ntc,
                                 input int pa, input int pl, input logic pterm,
                                 input logic inj, input logic hold);
        int e_cnt;
        int k;
        int done_e;
        int nxt;
        e_cnt = expEnabled(dir, sv, ntc);
        @(negedge CLK);
        START = 1'b1;
        DIR = dir;
        START_VAL = sv;
        NUM_TC = ntc;
        k = cyc + 1;
        done_e = k + 2 + e_cnt + pl;
        sb.push_back('{done_e, int'(ntc), int'(inj)});
        while (cyc < done_e + 2) begin
            @(negedge CLK);
            if (cyc == k) begin
                checkOutput("clear_c_mr", int'(C_MR), 1);
                checkOutput("clear_busy", int'(BUSY), 1);
                checkOutput("start_err_clr", int'(ERR), 0);
                checkOutput("start_tc_clr", int'(TC_CNT), 0);
            end else if (cyc == k + 1) begin
                checkOutput("load_c_load", int'(C_Load), 0);
                checkOutput("load_c_d", int'(C_D), int'(sv));
                checkOutput("load_dir", int'(C_Up_Dn), int'(dir));
            end else if (cyc == k + 2) begin
                checkOutput("run_c_en", int'(C_EN), int'(!(pa == 0 && pl > 0)));
                checkOutput("run_c_load", int'(C_Load), 1);
            end
            nxt = cyc + 1;
            START = hold && (nxt < done_e);
            PAUSE = ((nxt >= k + 2 + pa) && (nxt < k + 2 + pa + pl)) || (pterm && nxt == done_e);
            fault = inj && (cyc == k + 3);
        end
        START = 1'b0;
        PAUSE = 1'b0;
        fault = 1'b0;
        if (sb.size() != 0) begin
            checkOutput("done_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    // Sequence cut short by MR in the middle of RUN: must not produce DONE.
    task automatic abortTest();
        int k;
        @(negedge CLK);
        START = 1'b1;
        DIR = 1'b1;
        START_VAL = 4'd0;
        NUM_TC = 4'd3;
        k = cyc + 1;
        @(negedge CLK);
        START = 1'b0;
        repeat (9) @(negedge CLK);
        checkOutput("abort_running", int'(C_EN), 1);
        MR = 1'b1;
        @(negedge CLK);
        checkReset("abort");
        MR = 1'b0;
        repeat (40) @(negedge CLK);
        checkOutput("abort_idle_busy", int'(BUSY), 0);
        if (k < 0) $display("[TB] unreachable");
    endtask

    // Monitor: every DONE pulse retires the oldest expected sequence.
    always @(negedge CLK) begin
        if (!MR && DONE) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_done", int'(DONE), 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("done_edge", cyc, e.done_edge);
                checkOutput("done_tc_cnt", int'(TC_CNT), e.tc);
                checkOutput("done_err", int'(ERR), e.err);
                checkOutput("done_busy", int'(BUSY), 1);
                checkOutput("done_c_en", int'(C_EN), 0);
            end
        end
    end

    // Hard stop in case something wedges the run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int e_cnt;
        int pl;
        int pa;
        logic       rdir;
        logic [3:0] rsv;
        logic [3:0] rntc;
        $display("[TB] cnt_seq test starting");
        MR = 1'b1;
        repeat (3) @(negedge CLK);
        checkReset("reset");
        MR = 1'b0;
        repeat (2) @(negedge CLK);

        applyStimulus(1'b1, 4'd13, 4'd1, 0, 0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd2, 4'd2, 0, 0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd0, 4'd0, 0, 0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd5, 4'd1, 3, 5, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd3, 4'd1, 0, 0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd4, 4'd1, 0, 0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'd9, 4'd1, 1, 2, 1'b0, 1'b0, 1'b1);
        abortTest();

        for (int i = 0; i < 20; i++) begin
            rdir = 1'($urandom_range(0, 1));
            rsv = 4'($urandom_range(0, 15));
            rntc = 4'($urandom_range(0, 3));
            e_cnt = expEnabled(rdir, rsv, rntc);
            pl = int'($urandom_range(0, 4));
            pa = int'($urandom_range(0, e_cnt - 1));
            applyStimulus(rdir, rsv, rntc, pa, pl, 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cnt_seq.md
# cnt_seq

Command sequencer and checker for the 4-bit up/down counter used in this design. It drives the counter's control interface (MR, Load, EN, Up_Dn, D) through a clear/load/run sequence. It tracks the counter's terminal-count (CO) pulses and stops after a requested number of wraps. A shadow model compares the counter's Q output every cycle and flags any mismatch, so the block can sit beside the counter in hardware or on a bench.

## Interface
- No parameters; all widths are fixed at 4 bits to match the counter.
- CLK  in  1  system clock; all logic on rising edge
- MR  in  1  synchronous, active-high reset of this block
- START  in  1  begin a sequence; sampled only in IDLE
- DIR  in  1  count direction for the sequence; 1 = up, 0 = down
- START_VAL  in  4  value loaded into the counter
- NUM_TC  in  4  number of CO pulses to run; 0 means 16
- PAUSE  in  1  holds C_EN low while high in RUN
- Q_IN  in  4  counter Q
- CO_IN  in  1  counter CO
- C_MR  out  1  counter synchronous clear, active-high
- C_Load  out  1  counter parallel load, active-low
- C_EN  out  1  counter count enable, active-high
- C_Up_Dn  out  1  counter direction; 1 = up
- C_D  out  4  counter parallel data
- BUSY  out  1  high in every state except IDLE
- DONE  out  1  one-cycle pulse at the end of a sequence
- ERR  out  1  sticky mismatch flag
- TC_CNT  out  4  CO pulses seen in the current sequence

## Operation
- Counter contract:
  - MR=1 sets Q to 0 on the next edge.
  - Else Load=0 sets Q to D.
  - Else EN=1 steps Q ±1 mod 16.
  - CO is combinational: EN & (Q==15 when up, Q==0 when down).
- All outputs are registered.
- Reset values: C_MR=0, C_Load=1, C_EN=0, C_Up_Dn=0, C_D=0, BUSY=0, DONE=0, ERR=0, TC_CNT=0, state=IDLE, EXP=0.
- States:
  - IDLE: control outputs at their reset values. On START=1, latch DIR, START_VAL and NUM_TC, clear ERR and TC_CNT, then go to CLEAR.
  - CLEAR: C_MR=1 for one cycle, then LOAD.
  - LOAD: C_Load=0 and C_D=START_VAL for one cycle; C_Up_Dn=DIR from here to the end of the sequence. Then RUN.
  - RUN: C_EN = ~PAUSE.
    - Each CO_IN=1 sampled while C_EN=1 increments TC_CNT.
    - When the increment makes TC_CNT equal latched NUM_TC (mod 16; NUM_TC=0 ends at the 16th pulse), drive C_EN=0 on the following cycle and go to DONE.
  - DONE: DONE=1 for one cycle, control outputs idle, then IDLE.
- Shadow model: register EXP follows the registered command outputs with the counter's priority.
  - C_MR=1 → EXP=0.
  - Else C_Load=0 → EXP=C_D.
  - Else C_EN=1 → EXP±1 mod 16.
- Check: from the cycle after LOAD through DONE, Q_IN≠EXP sets ERR. ERR stays set until the next accepted START or MR.
- Simultaneous events:
  - START while BUSY is ignored.
  - PAUSE asserted on the cycle the terminal pulse is counted does not delay the transition to DONE.
  - MR wins over every condition.
- MR mid-sequence: returns to IDLE with reset values on the next edge. No DONE pulse is issued and C_MR is not driven.

## Timing
- START high at edge k:
  - k+1: C_MR=1.
  - k+2: C_Load=0.
  - k+3: C_EN=1, assuming PAUSE=0.
- Latency from first C_EN to DONE, with no pause:
  - Up: (16−START_VAL)+16·(N−1) edges, then +1 to DONE.
  - Down: START_VAL+1+16·(N−1), then +1.
- The Q_IN/EXP comparison is same-cycle: both reflect the previous edge's command.
- BUSY deasserts in the cycle after DONE.

## Test plan
- START, DIR=1, START_VAL=4'd13, NUM_TC=1 → C_EN high for 3 cycles, Q_IN 13,14,15,0, TC_CNT=1, DONE pulse, ERR=0.
- START, DIR=0, START_VAL=4'd2, NUM_TC=2 → Q_IN runs 2,1,0,15…0, TC_CNT=2, DONE after 19 enabled cycles, ERR=0.
- NUM_TC=0, DIR=1, START_VAL=0 → 16 CO pulses, TC_CNT wraps to 0, DONE after 256 enabled cycles.
- PAUSE high for 5 cycles in RUN → C_EN low for those cycles, Q_IN holds, EXP holds, ERR=0, DONE delayed by exactly 5 cycles.
- Force Q_IN to 4'd7 when EXP=4'd6 → ERR=1 next cycle and stays high through DONE; cleared by the next START.
- MR pulse in RUN → all outputs at reset values on the next cycle, no DONE; START high during BUSY → ignored.
